fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-side controller and occupancy tracker for the team's synchronous FIFO. It sits directly upstream of the read-pointer stage:
- accepts producer write requests;
- drives the storage RAM write port (address, enable, data);
- keeps the occupancy count and status flags;
- issues the qualified valid_rd strobe that advances the read pointer.

Reads are never granted when the FIFO is empty, and writes are never granted when it is full.

Parameters:
ADDR_WIDTH, 4, width of wr_addr; depth DEPTH = 2**ADDR_WIDTH (16).
DATA_WIDTH, 8, width of the write data path.
AFULL_THRESH, 12, almost_full asserts when count >= this value.
AEMPTY_THRESH, 4, almost_empty asserts when count <= this value.

Ports:
clk  input  1  clock, all logic on the rising edge.
reset  input  1  synchronous reset, active-high.
wr_req  input  1  producer write request.
wr_data  input  DATA_WIDTH  producer write data.
rd_req  input  1  consumer read request.
clr_err  input  1  clears the sticky error flags.
ram_we  output  1  RAM write enable, equal to wr_accept.
ram_waddr  output  ADDR_WIDTH  RAM write address, equal to the write pointer register.
ram_wdata  output  DATA_WIDTH  wr_data passed straight through.
valid_rd  output  1  read grant to the read pointer, equal to rd_accept.
count  output  ADDR_WIDTH+1  occupancy, range 0..DEPTH.
full  output  1  registered; high when count == DEPTH.
empty  output  1  registered; high when count == 0.
almost_full  output  1  registered.
almost_empty  output  1  registered.
overflow  output  1  sticky; a write was attempted while full.
underflow  output  1  sticky; a read was attempted while empty.

Behaviour:
- Reset (synchronous, active-high, on a rising edge while reset=1):
  - wr_ptr=0, count=0, state=S_EMPTY;
  - empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
  - The combinational outputs ram_we and valid_rd are forced to 0 while reset is high.
  - A reset mid-operation discards all occupancy; no write or read is granted in that cycle.
- Acceptance (combinational, based on the current registered flags):
  - wr_accept = wr_req & ~full;
  - rd_accept = rd_req & ~empty.
  - No bypass: a write while full is refused even if a read occurs in the same cycle. A read while empty is refused even if a write occurs in the same cycle.
- Write pointer: increments on wr_accept and wraps from DEPTH-1 to 0. ram_waddr shows the pre-increment value, so data lands at the current slot.
- Count: count_next = count + wr_accept - rd_accept, in ADDR_WIDTH+1 bit arithmetic. It never leaves 0..DEPTH.
- Simultaneous accepted write and read: count unchanged, wr_ptr advances, valid_rd=1.
- State machine (flags are decoded from the state and count registers):
  - S_EMPTY (count==0):
    - wr_accept & ~rd_accept -> S_PARTIAL;
    - otherwise stay.
  - S_PARTIAL (0<count<DEPTH):
    - count_next==0 -> S_EMPTY;
    - count_next==DEPTH -> S_FULL;
    - otherwise stay.
  - S_FULL (count==DEPTH):
    - rd_accept -> S_PARTIAL;
    - otherwise stay.
- Flag timing: all flags reflect the count after the edge. A write accepted at edge N means empty is low from edge N onward, i.e. visible the cycle after the request.
- Almost flags: almost_full = (count_next >= AFULL_THRESH); almost_empty = (count_next <= AEMPTY_THRESH). Both are registered alongside count.
- Error flags:
  - overflow is set on wr_req & full; underflow is set on rd_req & empty.
  - clr_err clears both on the next edge.
  - If a set condition and clr_err occur in the same cycle, set wins.
- Refused requests change no state other than the error flags.

Test Plan:
1. Reset, then 3 cycles of wr_req=1 -> ram_waddr 0,1,2 with ram_we=1; count=3 after the third edge; empty=0, almost_empty=1.
2. Write 16 entries back-to-back -> full=1 after the 16th edge, count=16, almost_full first high when count=12. A 17th wr_req gives ram_we=0 and overflow=1 next cycle; wr_ptr stays 0 (wrapped).
3. From full, rd_req=1 and wr_req=1 together -> valid_rd=1, ram_we=0, count=15, state S_PARTIAL, full=0.
4. From count=5, rd_req=1 and wr_req=1 together for 4 cycles -> count stays 5, valid_rd=1 and ram_we=1 each cycle, ram_waddr advances by 4.
5. From empty, rd_req=1 -> valid_rd=0, underflow=1 next cycle. Then clr_err=1 with rd_req=1 -> underflow stays 1. Then clr_err=1 alone -> underflow=0.
6. At count=9, assert reset with wr_req=1 -> no write granted; next cycle count=0, empty=1, ram_waddr=0, errors cleared.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller and occupancy tracker: grants are combinational off registered flags, and count/flags update on the edge.
// Writes are refused while full and reads are refused while empty, with no same-cycle bypass; a refused request only sets a sticky error flag.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  input  logic                  clr_err,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  valid_rd,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  full_flag;
  logic                  empty_flag;

  assign full_flag  = (state_q == S_FULL);
  assign empty_flag = (state_q == S_EMPTY);

  // Grants are masked during reset so a reset cycle never touches the RAM or read pointer.
  assign wr_accept = wr_req & ~full_flag & ~reset;
  assign rd_accept = rd_req & ~empty_flag & ~reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    count_d  = count_q + {{ADDR_WIDTH{1'b0}}, wr_accept} - {{ADDR_WIDTH{1'b0}}, rd_accept};
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    // A set condition takes priority over a clear in the same cycle.
    ovf_d = ovf_q;
    if (wr_req && full_flag) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end
    udf_d = udf_q;
    if (rd_req && empty_flag) begin
      udf_d = 1'b1;
    end else if (clr_err) begin
      udf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (wr_accept && !rd_accept) begin
          state_d = S_PARTIAL;
        end
      end
      S_PARTIAL: begin
        if (count_d == '0) begin
          state_d = S_EMPTY;
        end else if (count_d == DEPTH_C) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (rd_accept) begin
          state_d = S_PARTIAL;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_EMPTY;
      wr_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign ram_we       = wr_accept;
  assign ram_waddr    = wr_ptr_q;
  assign ram_wdata    = wr_data;
  assign valid_rd     = rd_accept;
  assign count        = count_q;
  assign full         = full_flag;
  assign empty        = empty_flag;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: inputs change 1 time unit after each rising edge, and outputs are checked before the next edge.
module tb_fifo_wr_ctrl;

  logic       clk;
  logic       reset;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       rd_req;
  logic       clr_err;
  logic       ram_we;
  logic [3:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic       valid_rd;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  fifo_wr_ctrl #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .AFULL_THRESH(12), .AEMPTY_THRESH(4)
  ) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data),
    .rd_req(rd_req), .clr_err(clr_err), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .valid_rd(valid_rd),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; wr_req = 1'b0; wr_data = 8'h00; rd_req = 1'b0; clr_err = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    chk("rst_waddr", 32'(ram_waddr), 0);
    wr_req = 1'b1; rd_req = 1'b1;
    #1;
    chk("rst_we_masked", 32'(ram_we), 0);
    chk("rst_vrd_masked", 32'(valid_rd), 0);

    // Test 1: three writes
    tick();
    reset = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'hA0 + 8'(i);
      #1;
      chk("t1_we", 32'(ram_we), 1);
      chk("t1_waddr", 32'(ram_waddr), 32'(i));
      chk("t1_wdata", 32'(ram_wdata), 32'(8'hA0 + 8'(i)));
      tick();
    end
    chk("t1_count", 32'(count), 3);
    chk("t1_empty", 32'(empty), 0);
    chk("t1_aempty", 32'(almost_empty), 1);

    // Test 2: fill to 16, then one refused write
    for (int i = 3; i < 16; i++) begin
      chk("t2_waddr", 32'(ram_waddr), 32'(i));
      chk("t2_we", 32'(ram_we), 1);
      tick();
      chk("t2_count", 32'(count), 32'(i + 1));
      chk("t2_afull", 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
      chk("t2_full", 32'(full), (i + 1 == 16) ? 32'd1 : 32'd0);
      chk("t2_aempty", 32'(almost_empty), (i + 1 <= 4) ? 32'd1 : 32'd0);
    end
    chk("t2_we_full", 32'(ram_we), 0);
    chk("t2_waddr_wrap", 32'(ram_waddr), 0);
    tick();
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_count_hold", 32'(count), 16);
    chk("t2_waddr_hold", 32'(ram_waddr), 0);

    // Test 3: read+write while full -> only the read is granted
    rd_req = 1'b1;
    #1;
    chk("t3_vrd", 32'(valid_rd), 1);
    chk("t3_we", 32'(ram_we), 0);
    tick();
    chk("t3_count", 32'(count), 15);
    chk("t3_full", 32'(full), 0);
    chk("t3_empty", 32'(empty), 0);
    chk("t3_waddr", 32'(ram_waddr), 0);
    wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b1;
    tick();
    chk("t3_ovf_clr", 32'(overflow), 0);
    clr_err = 1'b0;

    // Drain 10 entries to reach count=5
    rd_req = 1'b1;
    repeat (10) tick();
    rd_req = 1'b0;
    chk("t4_count_pre", 32'(count), 5);
    chk("t4_aempty_pre", 32'(almost_empty), 0);

    // Test 4: simultaneous read+write for 4 cycles
    wr_req = 1'b1; rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_vrd", 32'(valid_rd), 1);
      chk("t4_we", 32'(ram_we), 1);
      chk("t4_waddr", 32'(ram_waddr), 32'(k));
      tick();
      chk("t4_count", 32'(count), 5);
    end
    chk("t4_waddr_end", 32'(ram_waddr), 4);

    // Test 5: drain to empty, then refused read and error clearing
    wr_req = 1'b0;
    tick();
    chk("t5_count4", 32'(count), 4);
    chk("t5_aempty4", 32'(almost_empty), 1);
    repeat (4) tick();
    chk("t5_count0", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_vrd_empty", 32'(valid_rd), 0);
    tick();
    chk("t5_udf_set", 32'(underflow), 1);
    clr_err = 1'b1;
    tick();
    chk("t5_udf_setwins", 32'(underflow), 1);
    rd_req = 1'b0;
    tick();
    chk("t5_udf_clr", 32'(underflow), 0);
    clr_err = 1'b0;
    // Read+write while empty: only the write is granted
    wr_req = 1'b1; rd_req = 1'b1;
    #1;
    chk("t5_nb_vrd", 32'(valid_rd), 0);
    chk("t5_nb_we", 32'(ram_we), 1);
    chk("t5_nb_waddr", 32'(ram_waddr), 4);
    tick();
    chk("t5_nb_count", 32'(count), 1);
    chk("t5_nb_udf", 32'(underflow), 1);

    // Test 6: reset at count=9 with a pending write
    rd_req = 1'b0;
    repeat (8) tick();
    chk("t6_count9", 32'(count), 9);
    chk("t6_waddr13", 32'(ram_waddr), 13);
    reset = 1'b1;
    #1;
    chk("t6_we_masked", 32'(ram_we), 0);
    tick();
    reset = 1'b0; wr_req = 1'b0;
    #1;
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_waddr", 32'(ram_waddr), 0);
    chk("t6_udf", 32'(underflow), 0);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_afull", 32'(almost_full), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
